// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: two-write-port register file with optional write-to-read bypass
// and a busy scoreboard that tracks outstanding destination writes.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1,
    parameter bit BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic w0, w1, iv, inc, dec0, dec1;

    assign w0 = wr0_en && !(ZERO_REG && wr0_addr == '0);
    assign w1 = wr1_en && !(ZERO_REG && wr1_addr == '0);
    assign iv = iss_en && !(ZERO_REG && iss_rd == '0);

    // A clear only counts when the bit really falls: an issue to the same
    // address keeps it set, and a second port hitting the same address is not a second clear.
    assign inc  = iv && !busy[iss_rd];
    assign dec0 = w0 && busy[wr0_addr] && !(iv && iss_rd == wr0_addr);
    assign dec1 = w1 && busy[wr1_addr] && !(iv && iss_rd == wr1_addr) && !(w0 && wr0_addr == wr1_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w1 && wr1_addr == ADDR_W'(i)) regs[i] <= wr1_data;
                else if (w0 && wr0_addr == ADDR_W'(i)) regs[i] <= wr0_data;
                if (iv && iss_rd == ADDR_W'(i)) busy[i] <= 1'b1;
                else if ((w0 && wr0_addr == ADDR_W'(i)) || (w1 && wr1_addr == ADDR_W'(i))) busy[i] <= 1'b0;
            end
            busy_cnt <= busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec0) - (ADDR_W+1)'(dec1);
        end
    end

    logic h1_1, h1_0, h2_1, h2_0;

    always_comb begin
        h1_1 = BYPASS && w1 && wr1_addr == rs1_addr;
        h1_0 = BYPASS && w0 && wr0_addr == rs1_addr;
        h2_1 = BYPASS && w1 && wr1_addr == rs2_addr;
        h2_0 = BYPASS && w0 && wr0_addr == rs2_addr;
        rs1_data = h1_1 ? wr1_data : h1_0 ? wr0_data : regs[rs1_addr];
        rs2_data = h2_1 ? wr1_data : h2_0 ? wr0_data : regs[rs2_addr];
        rs1_busy = busy[rs1_addr] && !(h1_1 || h1_0);
        rs2_busy = busy[rs2_addr] && !(h2_1 || h2_0);
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: scoreboard bench comparing bypass and non-bypass builds
// against an array-based reference model under directed and random traffic.
module tb_regfile_mp_sb;
    logic        clk = 0, rst = 0;
    logic [4:0]  rs1_addr = 0, rs2_addr = 0, wr0_addr = 0, wr1_addr = 0, iss_rd = 0;
    logic [31:0] wr0_data = 0, wr1_data = 0;
    logic        wr0_en = 0, wr1_en = 0, iss_en = 0;
    logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
    logic        rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
    logic [5:0]  busy_cnt, nb_busy_cnt;

    always #5 clk = ~clk;

    regfile_mp_sb #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .busy_cnt(busy_cnt)
    );

    regfile_mp_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data), .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .busy_cnt(nb_busy_cnt)
    );

    typedef struct {
        int          id;
        logic [31:0] d1, d2, nd1, nd2;
        logic        b1, b2, nb1, nb2;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    int          tests = 0, fails = 0, cyc_id = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, id, got, want);
        end
    endtask

    function automatic int popcnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic wv(input logic en, input logic [4:0] a);
        return en && a != 0;
    endfunction

    // Bypass read: port 1 write wins over port 0, else the stored value.
    function automatic logic [31:0] rd_byp(input logic [4:0] a);
        if (wv(wr1_en, wr1_addr) && wr1_addr == a) return wr1_data;
        if (wv(wr0_en, wr0_addr) && wr0_addr == a) return wr0_data;
        return m_regs[a];
    endfunction

    function automatic logic bz_byp(input logic [4:0] a);
        return m_busy[a] && !((wv(wr1_en, wr1_addr) && wr1_addr == a) || (wv(wr0_en, wr0_addr) && wr0_addr == a));
    endfunction

    task automatic cyc(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic ie, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2, input logic rs);
        exp_t e;
        @(posedge clk);
        #1;
        wr0_en = e0; wr0_addr = a0; wr0_data = d0;
        wr1_en = e1; wr1_addr = a1; wr1_data = d1;
        iss_en = ie; iss_rd = ird; rs1_addr = r1; rs2_addr = r2; rst = rs;
        if (rs) for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
        e.id = cyc_id++;
        e.d1 = rd_byp(r1); e.d2 = rd_byp(r2);
        e.b1 = bz_byp(r1); e.b2 = bz_byp(r2);
        e.nd1 = m_regs[r1]; e.nd2 = m_regs[r2];
        e.nb1 = m_busy[r1]; e.nb2 = m_busy[r2];
        e.cnt = 6'(popcnt());
        q.push_back(e);
        if (!rs) begin
            if (wv(e0, a0)) begin m_regs[a0] = d0; m_busy[a0] = 0; end
            if (wv(e1, a1)) begin m_regs[a1] = d1; m_busy[a1] = 0; end
            if (wv(ie, ird)) m_busy[ird] = 1;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rs1_data", e.id, rs1_data, e.d1);
                chk("rs2_data", e.id, rs2_data, e.d2);
                chk("rs1_busy", e.id, 32'(rs1_busy), 32'(e.b1));
                chk("rs2_busy", e.id, 32'(rs2_busy), 32'(e.b2));
                chk("busy_cnt", e.id, 32'(busy_cnt), 32'(e.cnt));
                chk("nb_rs1_data", e.id, nb_rs1_data, e.nd1);
                chk("nb_rs2_data", e.id, nb_rs2_data, e.nd2);
                chk("nb_rs1_busy", e.id, 32'(nb_rs1_busy), 32'(e.nb1));
                chk("nb_rs2_busy", e.id, 32'(nb_rs2_busy), 32'(e.nb2));
                chk("nb_busy_cnt", e.id, 32'(nb_busy_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic r;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 5, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 1);
        cyc(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        cyc(1, 7, 32'h1111, 1, 7, 32'h2222, 0, 0, 7, 7, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
        cyc(1, 3, 32'hA5A5, 0, 0, 0, 0, 0, 0, 3, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
        cyc(0, 0, 0, 1, 9, 32'h9999, 0, 0, 9, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 4, 4, 0, 0);
        cyc(1, 4, 32'h4444, 0, 0, 0, 1, 4, 4, 4, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 499) == 0);
            cyc(!r && $urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom,
                !r && $urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom,
                !r && $urandom_range(0, 9) < 5, 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), r);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
